// File: rtl/layer_scheduler_if.sv
// Handshake bundle between a frame controller and layer_scheduler.
// master: frame controller / stage engines side; slave: the scheduler.
interface layer_scheduler_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_layers;
    logic [5:0]       stage_done;
    logic [5:0]       stage_start;
    logic [2:0]       stage_idx;
    logic [CNT_W-1:0] layer_cnt;
    logic             busy;
    logic             frame_done;
    logic             error;

    modport master (
        output start, abort, num_layers, stage_done,
        input  stage_start, stage_idx, layer_cnt, busy, frame_done, error
    );

    modport slave (
        input  start, abort, num_layers, stage_done,
        output stage_start, stage_idx, layer_cnt, busy, frame_done, error
    );
endinterface

// File: rtl/layer_scheduler.sv
// layer_scheduler: sequences one frame through FETCH, (CONV, POOL, ACT) x N,
// FC, DET. Each stage gets a one-cycle launch pulse and the scheduler then
// waits for that stage's done bit; done bits of other stages are ignored.
// A done seen in the launch cycle itself advances straight to the next launch.
// Optional macro LAYER_SCHED_TIMEOUT_EN adds a per-stage watchdog and an ERR
// state with a sticky error flag.
module layer_scheduler #(
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               rst_n,
    layer_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
`ifdef LAYER_SCHED_TIMEOUT_EN
        , S_ERR = 2'd3
`endif
    } state_t;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_CONV  = 3'd1;
    localparam logic [2:0] ST_ACT   = 3'd3;
    localparam logic [2:0] ST_FC    = 3'd4;
    localparam logic [2:0] ST_DET   = 3'd5;

    // Elaboration-time sanity on the configuration.
    if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("layer_scheduler: CNT_W and TIMEOUT_CYCLES must be >= 1");
    end

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] layer_q, layer_d;
    logic [CNT_W-1:0] nl_q, nl_d;
    logic [5:0]       start_q, start_d;
    logic             busy_q, busy_d;
    logic             fdone_q, fdone_d;
    logic             done_hit;
    logic             idle_like;

`ifdef LAYER_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_ERR);
    assign bus.error = err_q;
`else
    assign idle_like = (state_q == S_IDLE);
    assign bus.error = 1'b0;
`endif

    assign done_hit = bus.stage_done[idx_q];

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= ST_FETCH;
            layer_q <= '0;
            nl_q    <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
`ifdef LAYER_SCHED_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            layer_q <= layer_d;
            nl_q    <= nl_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
`ifdef LAYER_SCHED_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state: start acceptance, stage advance, abort and watchdog.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        layer_d = layer_q;
        nl_d    = nl_q;
        fdone_d = 1'b0;
`ifdef LAYER_SCHED_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        if (idle_like) begin
            if (bus.start) begin
                state_d = S_ISSUE;
                idx_d   = ST_FETCH;
                layer_d = '0;
                // A zero pass count still runs one conv/pool/act pass.
                nl_d    = (bus.num_layers == '0) ? CNT_W'(1) : bus.num_layers;
`ifdef LAYER_SCHED_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
        end else if (bus.abort) begin
            // Abort wins over a done arriving in the same cycle.
            state_d = S_IDLE;
        end else if (done_hit) begin
            state_d = S_ISSUE;
            case (idx_q)
                ST_ACT: begin
                    if (layer_q < nl_q - CNT_W'(1)) begin
                        idx_d   = ST_CONV;
                        layer_d = layer_q + CNT_W'(1);
                    end else begin
                        idx_d = ST_FC;
                    end
                end
                ST_DET: begin
                    state_d = S_IDLE;
                    fdone_d = 1'b1;
                end
                default: idx_d = idx_q + 3'd1;
            endcase
        end else begin
            state_d = S_WAIT;
`ifdef LAYER_SCHED_TIMEOUT_EN
            if (state_q == S_WAIT && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end
`endif
        end
`ifdef LAYER_SCHED_TIMEOUT_EN
        // Watchdog restarts with every launch and counts only while waiting.
        if (state_q == S_ISSUE)
            tmo_d = '0;
        else if (state_q == S_WAIT)
            tmo_d = tmo_q + TMO_W'(1);
`endif
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        start_d = '0;
        busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT);
        if (state_d == S_ISSUE)
            start_d = 6'b000001 << idx_d;
    end

    assign bus.stage_start = start_q;
    assign bus.stage_idx   = idx_q;
    assign bus.layer_cnt   = layer_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = fdone_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: table-driven frames, randomized
// frames against a stage-sequence model, and hand-written corner sequences.
module tb_layer_scheduler;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   negc = 0;

    layer_scheduler_if #(.CNT_W(CNT_W)) bus();

    layer_scheduler #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nl;
        int dly;
        int exp_pulses;
        int exp_cycles;
        int exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        negc++;
    endtask

    // Drives one whole frame starting at the current negedge. Expected launch
    // order comes from the stage rules; each launch must appear exactly one
    // cycle after the done that ends the previous stage.
    task automatic run_frame(input int nl, input int dmin, input int dmax, input bit noise,
                             output int pulses, output int cycles, output int last_layer);
        int eidx[$];
        int elay[$];
        int eff, p, s, expect_at, done_neg, cur;
        bit fd_seen;
        logic [5:0] bits;
        eff = (nl == 0) ? 1 : nl;
        eidx.push_back(0); elay.push_back(0);
        for (int l = 0; l < eff; l++) begin
            for (int st = 1; st <= 3; st++) begin
                eidx.push_back(st); elay.push_back(l);
            end
        end
        eidx.push_back(4); elay.push_back(eff - 1);
        eidx.push_back(5); elay.push_back(eff - 1);

        bus.start = 1'b1;
        bus.num_layers = nl[CNT_W-1:0];
        bus.abort = 1'b0;
        bus.stage_done = noise ? (6'($urandom) & 6'b111110) : 6'b0;
        s = negc; expect_at = s + 1; p = 0; pulses = 0; fd_seen = 0;
        done_neg = -1; cur = 0; last_layer = -1;
        while (!fd_seen && (negc - s) < 600) begin
            tick();
            bus.start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (negc == expect_at && p < eidx.size()) begin
                chk("launch_onehot", int'(bus.stage_start), 1 << eidx[p]);
                chk("launch_idx", int'(bus.stage_idx), eidx[p]);
                chk("launch_layer", int'(bus.layer_cnt), elay[p]);
                chk("launch_busy", int'(bus.busy), 1);
                pulses++;
                cur = eidx[p];
                done_neg = negc + $urandom_range(dmin, dmax);
                p++;
            end else if (negc == expect_at) begin
                chk("frame_done", int'({bus.frame_done, bus.busy, |bus.stage_start}), 3'b100);
                chk("held_layer", int'(bus.layer_cnt), elay[elay.size()-1]);
                last_layer = int'(bus.layer_cnt);
                fd_seen = 1;
            end else begin
                chk("gap_quiet", int'({bus.stage_start, bus.frame_done, bus.busy}), 1);
            end
            if (fd_seen) begin
                bus.start = 1'b0;
                bus.stage_done = 6'b0;
            end else begin
                bits = noise ? (6'($urandom) & ~(6'b000001 << cur)) : 6'b0;
                if (negc == done_neg) begin
                    bits[cur] = 1'b1;
                    expect_at = negc + 1;
                end
                bus.stage_done = bits;
            end
        end
        if (!fd_seen) chk("frame_timeout", 0, 1);
        cycles = negc - s;
    endtask

    // Starts a frame and answers every launch immediately until the launch of
    // stage tgt in pass tlay is visible; returns on that negedge.
    task automatic go_to_stage(input int nl, input int tgt, input int tlay);
        bit found = 0;
        bus.start = 1'b1;
        bus.num_layers = nl[CNT_W-1:0];
        bus.stage_done = 6'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (int'(bus.stage_start) == (1 << tgt) && int'(bus.layer_cnt) == tlay) begin
                found = 1;
                break;
            end
            bus.stage_done = bus.stage_start;
            tick();
        end
        bus.stage_done = 6'b0;
        chk("reach_stage", int'(found), 1);
    endtask

    initial begin
        int pulses, cycles, last, nl;
        vecs[0] = '{nl: 2,  dly: 3, exp_pulses: 9,  exp_cycles: 37, exp_last: 1};
        vecs[1] = '{nl: 0,  dly: 0, exp_pulses: 6,  exp_cycles: 7,  exp_last: 0};
        vecs[2] = '{nl: 1,  dly: 1, exp_pulses: 6,  exp_cycles: 13, exp_last: 0};
        vecs[3] = '{nl: 3,  dly: 0, exp_pulses: 12, exp_cycles: 13, exp_last: 2};
        vecs[4] = '{nl: 15, dly: 0, exp_pulses: 48, exp_cycles: 49, exp_last: 14};
        vecs[5] = '{nl: 4,  dly: 2, exp_pulses: 15, exp_cycles: 46, exp_last: 3};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_layers = '0;
        bus.stage_done = '0;

        // Reset state
        #3;
        chk("rst_stage_start", int'(bus.stage_start), 0);
        chk("rst_stage_idx", int'(bus.stage_idx), 0);
        chk("rst_layer_cnt", int'(bus.layer_cnt), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_error", int'(bus.error), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", int'(bus.busy), 0);

        // Table-driven frames, back to back (start in the frame_done cycle)
        foreach (vecs[i]) begin
            run_frame(vecs[i].nl, vecs[i].dly, vecs[i].dly, 1'b0, pulses, cycles, last);
            chk("tbl_pulses", pulses, vecs[i].exp_pulses);
            chk("tbl_cycles", cycles, vecs[i].exp_cycles);
            chk("tbl_last_layer", last, vecs[i].exp_last);
        end

        // Randomized frames with stray done bits and ignored starts
        for (int f = 0; f < 24; f++) begin
            nl = $urandom_range(0, 4);
            run_frame(nl, 0, 3, 1'b1, pulses, cycles, last);
            chk("rnd_pulses", pulses, 3 * ((nl == 0) ? 1 : nl) + 3);
        end
        tick();

        // Stray FC done and start while waiting on CONV
        go_to_stage(1, 1, 0);
        bus.stage_done = 6'b010000;
        bus.start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stray_quiet", int'({bus.stage_start, bus.busy, bus.stage_idx}), 'b000000_1_001);
        end
        bus.stage_done = 6'b0;
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle", int'({bus.busy, bus.frame_done, |bus.stage_start}), 0);
        tick();
        chk("abort_no_fd", int'(bus.frame_done), 0);

        // Abort together with POOL done
        go_to_stage(1, 2, 0);
        bus.abort = 1'b1;
        bus.stage_done = 6'b000100;
        tick();
        bus.abort = 1'b0;
        bus.stage_done = 6'b0;
        chk("abort_pool_busy", int'(bus.busy), 0);
        chk("abort_pool_start", int'(bus.stage_start), 0);
        chk("abort_pool_fd", int'(bus.frame_done), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_pool_after", int'({bus.stage_start, bus.frame_done, bus.busy}), 0);
        end
        // Abort in IDLE does nothing
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_in_idle", int'({bus.busy, bus.stage_start}), 0);

        // Reset in the middle of the second ACT wait
        go_to_stage(2, 3, 1);
        tick();
        chk("pre_rst_busy", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", int'(bus.stage_start), 0);
        chk("mid_rst_idx", int'(bus.stage_idx), 0);
        chk("mid_rst_layer", int'(bus.layer_cnt), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_fd", int'(bus.frame_done), 0);
        chk("mid_rst_err", int'(bus.error), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_quiet", int'({bus.stage_start, bus.frame_done, bus.busy}), 0);
        end

`ifdef LAYER_SCHED_TIMEOUT_EN
        // FC done withheld: 16 waiting cycles then ERR
        go_to_stage(0, 4, 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("tmo_waiting", int'({bus.busy, bus.error}), 2'b10);
        end
        tick();
        chk("tmo_err", int'({bus.busy, bus.error, |bus.stage_start}), 3'b010);
        tick(); tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("tmo_sticky", int'(bus.error), 1);
        bus.start = 1'b1;
        bus.num_layers = '0;
        tick();
        bus.start = 1'b0;
        chk("tmo_clear_err", int'(bus.error), 0);
        chk("tmo_restart", int'({bus.stage_start, bus.busy}), 'b000001_1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
`else
        // No watchdog: a withheld done keeps the scheduler waiting
        go_to_stage(0, 4, 0);
        for (int k = 0; k < 40; k++) tick();
        chk("no_tmo_wait", int'({bus.busy, bus.error, |bus.stage_start}), 3'b100);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("no_tmo_abort", int'(bus.busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
